// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with iterative shifts and shift-add multiply behind valid/ready handshakes
module alu_mc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   alu_cmd,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         sc_i,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] rslt,
  output logic [W-1:0] rslt_hi,
  output logic         sc_o,
  output logic         pari,
  output logic         zero,
  output logic         one,
  output logic         err
);
  localparam int SHW = $clog2(W);
  localparam logic [3:0] MUL = 4'b1011;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t           r_state;
  logic [3:0]       r_cmd;
  logic [W-1:0]     r_a;
  logic [2*W-1:0]   r_acc;
  logic [SHW:0]     r_cnt;
  logic [W-1:0]     r_rslt, r_hi;
  logic             r_sc, r_pari, r_zero, r_one, r_err;
  logic             w_acc, w_multi, w_last, w_fin, w_shc, w_sc, w_err;
  logic [SHW-1:0]   w_amt;
  logic [W:0]       w_sum, w_diff, w_madd;
  logic [W-1:0]     w_sh, w_res, w_hi;
  logic [2*W-1:0]   w_nacc;
  assign in_ready  = !reset && (r_state == IDLE || (r_state == DONE && out_ready));
  assign out_valid = r_state == DONE;
  assign rslt      = r_rslt;
  assign rslt_hi   = r_hi;
  assign sc_o      = r_sc;
  assign pari      = r_pari;
  assign zero      = r_zero;
  assign one       = r_one;
  assign err       = r_err;
  assign w_amt   = inB[SHW-1:0];
  assign w_acc   = in_valid && in_ready;
  assign w_multi = alu_cmd == MUL || (alu_cmd[3:1] == 3'b011 && w_amt != '0);
  assign w_last  = r_state == EXEC && r_cnt == (SHW+1)'(1);
  assign w_fin   = (w_acc && !w_multi) || w_last;
  assign w_sum   = {1'b0, inA} + {1'b0, inB} + (W+1)'(sc_i);
  assign w_diff  = {1'b0, inA} - {1'b0, inB};
  assign w_sh    = r_cmd[0] ? r_acc[W-1:0] >> 1 : r_acc[W-1:0] << 1;
  assign w_shc   = r_cmd[0] ? r_acc[0] : r_acc[W-1];
  // multiplier sits in the low half of the accumulator and is consumed as the product shifts in
  assign w_madd  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_nacc  = r_cmd == MUL ? {w_madd, r_acc[W-1:1]} : {{W{1'b0}}, w_sh};
  always_comb begin
    w_res = '0;
    w_hi  = '0;
    w_sc  = 1'b0;
    w_err = 1'b0;
    if (r_state == EXEC) begin
      w_res = w_nacc[W-1:0];
      w_hi  = r_cmd == MUL ? w_nacc[2*W-1:W] : '0;
      w_sc  = r_cmd != MUL && w_shc;
    end else
      case (alu_cmd)
        4'b0000: {w_sc, w_res} = w_sum;
        4'b0001: {w_sc, w_res} = w_diff;
        4'b0010: w_res = inA & inB;
        4'b0011: w_res = inA | inB;
        4'b0100: w_res = inA ^ inB;
        4'b0101: w_res = ~(inA | inB);
        4'b0110, 4'b0111: w_res = inA;
        4'b1000: w_res = W'(inA == inB);
        4'b1001: w_res = W'(inA < inB);
        4'b1010: w_res = W'(^inB);
        4'b1011: w_res = '0;
        4'b1100: w_res = inB;
        default: w_err = 1'b1;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cmd   <= '0;
      r_a     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_rslt  <= '0;
      r_hi    <= '0;
      r_sc    <= 1'b0;
      r_pari  <= 1'b0;
      r_zero  <= 1'b0;
      r_one   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_fin) begin
        r_rslt <= w_res;
        r_hi   <= w_hi;
        r_sc   <= w_sc;
        r_pari <= ^w_res;
        r_zero <= w_res == '0;
        r_err  <= w_err;
      end
      if (w_acc && alu_cmd[3:1] == 3'b100) r_one <= w_res[0];
      if (w_acc) begin
        r_cmd   <= alu_cmd;
        r_a     <= inA;
        r_cnt   <= alu_cmd == MUL ? (SHW+1)'(W) : (SHW+1)'(w_amt);
        r_acc   <= {{W{1'b0}}, alu_cmd == MUL ? inB : inA};
        r_state <= w_multi ? EXEC : DONE;
      end else if (r_state == EXEC) begin
        r_acc <= w_nacc;
        r_cnt <= r_cnt - (SHW+1)'(1);
        if (w_last) r_state <= DONE;
      end else if (r_state == DONE && out_ready)
        r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and random operations on alu_mc checked against an arithmetic reference with latency tracking
module tb_alu_mc;
  localparam int W = 8;
  typedef struct packed {
    logic [W-1:0] lo, hi;
    logic         sc, er, zf, pf;
    logic [7:0]   lat;
  } res_t;
  logic         clk = 1'b0, reset = 1'b1, sc_i = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0]   alu_cmd = '0;
  logic [W-1:0] inA = '0, inB = '0;
  logic         in_ready, out_valid, sc_o, pari, zero, one, err;
  logic [W-1:0] rslt, rslt_hi;
  int           n_chk = 0, n_err = 0;
  int           m_ph = 0, m_left = 0;
  logic         m_one = 1'b0, m_clean = 1'b1, m_on = 1'b0;
  res_t         m_r = '0, m_p = '0, m_now;

  alu_mc #(.W(W)) dut (
    .clk(clk), .reset(reset), .alu_cmd(alu_cmd), .inA(inA), .inB(inB), .sc_i(sc_i),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .rslt(rslt), .rslt_hi(rslt_hi), .sc_o(sc_o), .pari(pari), .zero(zero), .one(one), .err(err)
  );

  always #5 clk = ~clk;

  function automatic res_t ref_op(input logic [3:0] c, input logic [W-1:0] a, b, input logic ci);
    res_t r;
    int n;
    logic [2*W-1:0] p;
    r = '0;
    r.lat = 8'd1;
    n = int'(b) % W;
    case (c)
      4'd0: {r.sc, r.lo} = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
      4'd1: begin r.lo = a - b; r.sc = a < b; end
      4'd2: r.lo = a & b;
      4'd3: r.lo = a | b;
      4'd4: r.lo = a ^ b;
      4'd5: r.lo = ~(a | b);
      4'd6: begin r.lo = a << n; if (n != 0) r.sc = a[W-n]; r.lat = 8'(n + 1); end
      4'd7: begin r.lo = a >> n; if (n != 0) r.sc = a[n-1]; r.lat = 8'(n + 1); end
      4'd8: r.lo = W'(a == b);
      4'd9: r.lo = W'(a < b);
      4'd10: r.lo = W'(^b);
      4'd11: begin p = (2*W)'(a) * (2*W)'(b); r.lo = p[W-1:0]; r.hi = p[2*W-1:W]; r.lat = 8'(W + 1); end
      4'd12: r.lo = b;
      default: r.er = 1'b1;
    endcase
    r.zf = r.lo == '0;
    r.pf = ^r.lo;
    return r;
  endfunction

  assign m_now = ref_op(alu_cmd, inA, inB, sc_i);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: a result appears 'lat' cycles after acceptance and waits for the response handshake
  always @(posedge clk) begin
    m_on <= 1'b1;
    if (reset) begin
      m_ph <= 0;
      m_one <= 1'b0;
      m_r <= '0;
      m_clean <= 1'b1;
    end else if (in_valid && (m_ph == 0 || (m_ph == 2 && out_ready))) begin
      m_clean <= 1'b0;
      if (m_now.lat == 8'd1) begin
        m_ph <= 2;
        m_r <= m_now;
        if (alu_cmd == 4'd8 || alu_cmd == 4'd9) m_one <= m_now.lo[0];
      end else begin
        m_ph <= 1;
        m_left <= int'(m_now.lat) - 1;
        m_p <= m_now;
      end
    end else if (m_ph == 1) begin
      if (m_left == 1) begin
        m_ph <= 2;
        m_r <= m_p;
      end
      m_left <= m_left - 1;
    end else if (m_ph == 2 && out_ready)
      m_ph <= 0;
  end

  always @(negedge clk) if (m_on) begin
    chk("in_ready", 64'(in_ready), 64'(!reset && (m_ph == 0 || (m_ph == 2 && out_ready))));
    chk("out_valid", 64'(out_valid), 64'(m_ph == 2));
    chk("one", 64'(one), 64'(m_one));
    if (m_ph == 2 || m_clean) begin
      chk("rslt", 64'(rslt), 64'(m_r.lo));
      chk("rslt_hi", 64'(rslt_hi), 64'(m_r.hi));
      chk("sc_o", 64'(sc_o), 64'(m_r.sc));
      chk("err", 64'(err), 64'(m_r.er));
      chk("zero", 64'(zero), 64'(m_r.zf));
      chk("pari", 64'(pari), 64'(m_r.pf));
    end
  end

  task automatic do_op(input logic [3:0] c, input logic [W-1:0] a, b, input logic ci, output int lat);
    int k;
    @(posedge clk); #1;
    alu_cmd = c; inA = a; inB = b; sc_i = ci; in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    chk("accept", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; inA = ~a; inB = ~b;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 40);
    chk("done_wait", 64'(out_valid), 64'(1));
  endtask

  initial begin
    res_t e;
    int lat;
    e = ref_op(4'd0, 8'hFF, 8'h01, 1'b1);
    chk("pin_add", 64'({e.sc, e.lo, e.lat, e.zf, e.pf}), 64'({1'b1, 8'h01, 8'd1, 1'b0, 1'b1}));
    e = ref_op(4'd6, 8'h81, 8'h03, 1'b0);
    chk("pin_sll3", 64'({e.sc, e.lo, e.lat}), 64'({1'b0, 8'h08, 8'd4}));
    e = ref_op(4'd7, 8'h81, 8'h01, 1'b0);
    chk("pin_srl1", 64'({e.sc, e.lo, e.lat}), 64'({1'b1, 8'h40, 8'd2}));
    e = ref_op(4'd11, 8'hFF, 8'hFF, 1'b0);
    chk("pin_mul", 64'({e.hi, e.lo, e.lat}), 64'({8'hFE, 8'h01, 8'd9}));
    e = ref_op(4'd14, 8'h12, 8'h34, 1'b0);
    chk("pin_ill", 64'({e.er, e.lo}), 64'({1'b1, 8'h00}));
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_outs", 64'({out_valid, rslt, rslt_hi, sc_o, pari, zero, one, err}), 64'(0));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'(1));
    do_op(4'd0, 8'hFF, 8'h01, 1'b1, lat);
    chk("add_lat", 64'(lat), 64'(1));
    chk("add_res", 64'({rslt, sc_o, zero, pari}), 64'({8'h01, 1'b1, 1'b0, 1'b1}));
    do_op(4'd6, 8'h81, 8'h03, 1'b0, lat);
    chk("sll3_lat", 64'(lat), 64'(4));
    chk("sll3_res", 64'({rslt, sc_o}), 64'({8'h08, 1'b0}));
    do_op(4'd6, 8'h81, 8'h00, 1'b0, lat);
    chk("sll0_lat", 64'(lat), 64'(1));
    chk("sll0_res", 64'({rslt, sc_o}), 64'({8'h81, 1'b0}));
    do_op(4'd7, 8'h81, 8'h01, 1'b0, lat);
    chk("srl1_res", 64'({lat[7:0], rslt, sc_o}), 64'({8'd2, 8'h40, 1'b1}));
    do_op(4'd11, 8'hFF, 8'hFF, 1'b0, lat);
    chk("mul_lat", 64'(lat), 64'(9));
    chk("mul_res", 64'({rslt_hi, rslt}), 64'({8'hFE, 8'h01}));
    do_op(4'd8, 8'h05, 8'h05, 1'b0, lat);
    chk("eq_one", 64'(one), 64'(1));
    do_op(4'd0, 8'h01, 8'h01, 1'b0, lat);
    chk("add_one_hold", 64'({one, rslt}), 64'({1'b1, 8'h02}));
    do_op(4'd9, 8'h07, 8'h03, 1'b0, lat);
    chk("lt_one", 64'(one), 64'(0));
    do_op(4'd1, 8'h03, 8'h05, 1'b0, lat);
    chk("sub_res", 64'({rslt, sc_o}), 64'({8'hFE, 1'b1}));
    for (int c = 2; c <= 12; c++) do_op(4'(c), 8'hA5, 8'h3C, 1'b1, lat);
    @(posedge clk); #1;
    out_ready = 1'b0; alu_cmd = 4'd3; inA = 8'h12; inB = 8'h34; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("stall_first", 64'({out_valid, rslt}), 64'({1'b1, 8'h36}));
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", 64'({out_valid, in_ready, rslt}), 64'({1'b1, 1'b0, 8'h36}));
    end
    @(posedge clk); #1;
    out_ready = 1'b1; alu_cmd = 4'd4; inA = 8'hF0; inB = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_xor", 64'({out_valid, rslt}), 64'({1'b1, 8'h0F}));
    do_op(4'd14, 8'h12, 8'h34, 1'b0, lat);
    chk("ill_res", 64'({lat[7:0], err, rslt}), 64'({8'd1, 1'b1, 8'h00}));
    do_op(4'd8, 8'h09, 8'h09, 1'b0, lat);
    chk("eq2_one", 64'(one), 64'(1));
    @(posedge clk); #1;
    alu_cmd = 4'd11; inA = 8'h12; inB = 8'h34; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", 64'(in_ready), 64'(1));
    chk("abort_outs", 64'({out_valid, rslt, rslt_hi, sc_o, pari, zero, one, err}), 64'(0));
    repeat (12) begin
      @(negedge clk);
      chk("abort_novalid", 64'(out_valid), 64'(0));
    end
    for (int i = 0; i < 40; i++)
      do_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), 1'($urandom), lat);
    @(posedge clk); #1;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
